mem_wb_writeback: RTL and testbench

MEM_WB_WRITEBACK -- requirements
Module: mem_wb_writeback

---
 rtl/mem_wb_writeback.sv | 80 ++++++++
 tb/tb_mem_wb_writeback.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with writeback data select, $zero write suppression,
// forwarding taps and a retired-instruction counter.
// Latency: 1 cycle from capture edge to outputs; forwarding outputs are combinational copies of the stage.
// Backpressure: stall holds the whole stage including the counter; flush inserts a bubble and wins over stall.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   stall, flush        hold stage / squash stage (flush has priority)
//   in_*                MEM-stage instruction fields
//   write_reg/data      registered register-file write index and data
//   RegWrite            registered register-file write enable
//   fwd_valid/reg/data  forwarding source for the hazard unit
//   retire_count        number of retired valid instructions, wraps modulo 2^CNT_WIDTH
module mem_wb_writeback #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic                 in_RegWrite,
  input  logic                 in_MemtoReg,
  input  logic                 in_link,
  input  logic [4:0]           in_write_reg,
  input  logic [31:0]          in_alu_result,
  input  logic [31:0]          in_mem_data,
  input  logic [31:0]          in_pc_plus4,
  output logic [4:0]           write_reg,
  output logic [31:0]          write_data,
  output logic                 RegWrite,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_reg,
  output logic [31:0]          fwd_data,
  output logic [CNT_WIDTH-1:0] retire_count
);

  logic [31:0] sel_data;
  logic        sel_we;

  // Return address beats load data, which beats the ALU result.
  always_comb begin
    sel_data = in_alu_result;
    if (in_link) begin
      sel_data = in_pc_plus4;
    end else if (in_MemtoReg) begin
      sel_data = in_mem_data;
    end
  end

  // Register 0 is hardwired, so a write to it never reaches the register file.
  assign sel_we = in_valid & in_RegWrite & (in_write_reg != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
      RegWrite     <= 1'b0;
      retire_count <= '0;
    end else if (flush) begin
      // Bubble: the squashed instruction did not retire, so the counter holds.
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
      RegWrite     <= 1'b0;
    end else if (!stall) begin
      // Index is captured even when the write is suppressed.
      write_reg  <= in_write_reg;
      write_data <= sel_data;
      RegWrite   <= sel_we;
      if (in_valid) begin
        retire_count <= retire_count + 1'b1;
      end
    end
  end

  assign fwd_valid = RegWrite;
  assign fwd_reg   = write_reg;
  assign fwd_data  = write_data;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Bench for mem_wb_writeback: directed literal checks plus randomized traffic
// compared every cycle against a behavioural model of the writeback stage.
module tb_mem_wb_writeback;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall = 1'b0, flush = 1'b0;
  logic          in_valid = 1'b0, in_RegWrite = 1'b0, in_MemtoReg = 1'b0, in_link = 1'b0;
  logic [4:0]    in_write_reg = '0;
  logic [31:0]   in_alu_result = '0, in_mem_data = '0, in_pc_plus4 = '0;
  logic [4:0]    write_reg, fwd_reg;
  logic [31:0]   write_data, fwd_data;
  logic          RegWrite, fwd_valid;
  logic [CW-1:0] retire_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  mem_wb_writeback #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_RegWrite(in_RegWrite), .in_MemtoReg(in_MemtoReg),
    .in_link(in_link), .in_write_reg(in_write_reg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc_plus4(in_pc_plus4),
    .write_reg(write_reg), .write_data(write_data), .RegWrite(RegWrite),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // What the register file should see next, plus an unbounded retire tally.
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  logic        m_we;
  int          m_retired;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reg <= 5'd0; m_data <= 32'd0; m_we <= 1'b0; m_retired <= 0;
    end else if (flush) begin
      m_reg <= 5'd0; m_data <= 32'd0; m_we <= 1'b0;
    end else if (!stall) begin
      m_reg     <= in_write_reg;
      m_data    <= in_link ? in_pc_plus4 : (in_MemtoReg ? in_mem_data : in_alu_result);
      m_we      <= in_valid && in_RegWrite && (in_write_reg != 5'd0);
      m_retired <= m_retired + (in_valid ? 1 : 0);
    end
  end

  // Single compare process: every cycle, on the falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_write_reg",  write_reg,  m_reg);
      chk("m_write_data", write_data, m_data);
      chk("m_RegWrite",   RegWrite,   m_we);
      chk("m_fwd_valid",  fwd_valid,  m_we);
      chk("m_fwd_reg",    fwd_reg,    m_reg);
      chk("m_fwd_data",   fwd_data,   m_data);
      chk("m_retire",     retire_count, m_retired % (1 << CW));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input bit v, input bit rw, input bit m2r, input bit lk,
                        input logic [4:0] r, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc4);
    in_valid = v; in_RegWrite = rw; in_MemtoReg = m2r; in_link = lk;
    in_write_reg = r; in_alu_result = alu; in_mem_data = mem; in_pc_plus4 = pc4;
  endtask

  // Called at a falling edge with inputs set: pass the rising edge, settle.
  task automatic edge_step();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string tag, input logic [4:0] r, input logic [31:0] d,
                         input bit we, input logic [CW-1:0] c);
    chk({tag, ".write_reg"},  write_reg,    r);
    chk({tag, ".write_data"}, write_data,   d);
    chk({tag, ".RegWrite"},   RegWrite,     we);
    chk({tag, ".fwd_valid"},  fwd_valid,    we);
    chk({tag, ".retire"},     retire_count, c);
  endtask

  initial begin
    // Reset held across clock edges with live inputs: nothing may be captured.
    set_in(1, 1, 0, 0, 5'd5, 32'h77, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 chk_out("reset", 5'd0, 32'd0, 0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;

    // ALU write
    set_in(1, 1, 0, 0, 5'd8, 32'h0000_002A, 32'h1111_1111, 32'h2222_2222);
    edge_step(); chk_out("alu", 5'd8, 32'h2A, 1, 4'd1); @(negedge clk);
    // load
    set_in(1, 1, 1, 0, 5'd9, 32'h3333_3333, 32'hDEAD_BEEF, 32'h4444_4444);
    edge_step(); chk_out("load", 5'd9, 32'hDEAD_BEEF, 1, 4'd2); @(negedge clk);
    // link wins over MemtoReg
    set_in(1, 1, 1, 1, 5'd31, 32'h5555_5555, 32'h6666_6666, 32'h0040_0008);
    edge_step(); chk_out("link", 5'd31, 32'h0040_0008, 1, 4'd3); @(negedge clk);
    // $zero suppression, index and data still captured
    set_in(1, 1, 0, 0, 5'd0, 32'd5, 32'h0, 32'h0);
    edge_step(); chk_out("zero", 5'd0, 32'd5, 0, 4'd4); @(negedge clk);
    // invalid instruction: no write, no retire
    set_in(0, 1, 0, 0, 5'd7, 32'h99, 32'h0, 32'h0);
    edge_step(); chk_out("invalid", 5'd7, 32'h99, 0, 4'd4); @(negedge clk);
    // capture reg 3, then stall with changing inputs
    set_in(1, 1, 0, 0, 5'd3, 32'h33, 32'h0, 32'h0);
    edge_step(); chk_out("cap3", 5'd3, 32'h33, 1, 4'd5); @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, i[0], 0, 5'(10 + i), $urandom, $urandom, $urandom);
      edge_step(); chk_out("stall", 5'd3, 32'h33, 1, 4'd5); @(negedge clk);
    end
    flush = 1'b1;
    edge_step(); chk_out("stall_flush", 5'd0, 32'd0, 0, 4'd5); @(negedge clk);
    flush = 1'b0;
    edge_step(); chk_out("stall_after_flush", 5'd0, 32'd0, 0, 4'd5); @(negedge clk);

    // Re-load something, then async reset while stalled and flushed.
    stall = 1'b0;
    set_in(1, 1, 0, 0, 5'd12, 32'hABCD, 32'h0, 32'h0);
    edge_step(); chk_out("pre_rst", 5'd12, 32'hABCD, 1, 4'd6); @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    #1 rst = 1'b0;
    #1 chk_out("rst_mid_stall", 5'd0, 32'd0, 0, 4'd0);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; flush = 1'b0;

    // Counter wrap: 17 valid retirements in a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
      @(negedge clk);
    end
    chk("wrap.retire", retire_count, 4'd1);
    set_in(0, 0, 0, 0, 5'd4, 32'h1, 32'h2, 32'h3);
    @(negedge clk);
    // Async reset between edges: outputs clear before the next rising edge.
    #1 rst = 1'b0;
    #1 chk_out("async_rst", 5'd0, 32'd0, 0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 99) < 20);
      flush = ($urandom_range(0, 99) < 10);
      set_in($urandom_range(0, 99) < 70, 1'($urandom), 1'($urandom), 1'($urandom),
             ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
             $urandom, $urandom, $urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
